// File: rtl/neuron_mac_pkg.sv
// Shared fixed-point defaults, FSM state encoding and a clog2 helper
// for the neuron MAC datapath.
package neuron_mac_pkg;

    localparam int unsigned N_DEF  = 16;
    localparam int unsigned Q_DEF  = 12;
    localparam int          FX_ONE = 1 << Q_DEF;
    localparam int          FX_MAX = (1 << (N_DEF - 1)) - 1;
    localparam int          FX_MIN = -FX_MAX;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        FIN   = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Ceiling log2, returns 0 for inputs of 0 or 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac_sat_rescale.sv
// Rescales the full-precision sum back to Q format (floor), clamps it
// symmetrically to +/-(2^(N-1)-1) and encodes it as sign-magnitude or
// two's complement. Purely combinational.
module fx_sat_rescale
    import neuron_mac_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned Q      = Q_DEF,
    parameter int unsigned ACCW   = 2 * N_DEF + 4,
    parameter bit          OUT_SM = 1'b1
) (
    input  logic signed [ACCW-1:0] s,
    output logic        [N-1:0]    phase,
    output logic                   ovf
);

    localparam logic signed [ACCW-1:0] PMAX = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACCW-1:0] NMAX = -PMAX;
    localparam logic        [N-1:0]    PMAX_N = {1'b0, {(N-1){1'b1}}};
    localparam logic        [N-1:0]    NMAX_N = {1'b1, {(N-2){1'b0}}, 1'b1};

    logic signed [ACCW-1:0] sh;
    logic                   hi;
    logic                   lo;
    logic        [N-1:0]    r_n;
    logic                   neg;
    logic        [N-2:0]    mag;

    assign sh = s >>> Q;

    // Clamp, then encode; the symmetric clamp keeps |r| within N-1 bits
    always_comb begin
        hi  = (sh > PMAX);
        lo  = (sh < NMAX);
        ovf = hi | lo;
        r_n = sh[N-1:0];
        if (hi) begin
            r_n = PMAX_N;
        end else if (lo) begin
            r_n = NMAX_N;
        end
        neg = r_n[N-1];
        mag = neg ? (~r_n[N-2:0] + {{(N-2){1'b0}}, 1'b1}) : r_n[N-2:0];
        if (OUT_SM) begin
            phase = {neg, mag};
        end else begin
            phase = r_n;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Streaming dot-product neuron: LEN (x,w) beats are multiplied into a
// product register, accumulated at full precision, biased, rescaled and
// saturated into one phase word for the activation LUT.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned Q      = Q_DEF,
    parameter int unsigned LEN    = 8,
    parameter bit          OUT_SM = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] bias,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] w,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] phase,
    output logic         ovf,
    output logic         busy
);

    localparam int unsigned ACCW = 2 * N + clog2(LEN) + 1;
    localparam int unsigned CW   = clog2(LEN + 1);

    state_t                 state;
    state_t                 state_nxt;
    logic        [CW-1:0]   count;
    logic signed [2*N-1:0]  prod;
    logic                   prod_valid;
    logic signed [ACCW-1:0] acc;
    logic        [N-1:0]    bias_q;
    logic signed [ACCW-1:0] sum;
    logic        [N-1:0]    sat_phase;
    logic                   sat_ovf;
    logic                   beat;
    logic                   last_beat;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign beat      = in_valid & in_ready;
    assign last_beat = beat & (count == CW'(LEN - 1));

    assign sum = acc + ({{(ACCW-N){bias_q[N-1]}}, bias_q} <<< Q);

    fx_sat_rescale #(
        .N      (N),
        .Q      (Q),
        .ACCW   (ACCW),
        .OUT_SM (OUT_SM)
    ) u_sat (
        .s      (sum),
        .phase  (sat_phase),
        .ovf    (sat_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (last_beat) state_nxt = DRAIN;
            DRAIN:   state_nxt = FIN;
            FIN:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: beat counter, product pipeline, accumulator, output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
            bias_q     <= '0;
            phase      <= '0;
            ovf        <= 1'b0;
        end else begin
            // The accumulator trails the product register by one cycle, so
            // the last product is folded in during DRAIN.
            prod_valid <= beat;
            if (prod_valid) begin
                acc <= acc + {{(ACCW-2*N){prod[2*N-1]}}, prod};
            end
            if (beat) begin
                prod  <= $signed(x) * $signed(w);
                count <= count + CW'(1);
            end
            if (state == IDLE && start) begin
                acc        <= '0;
                count      <= '0;
                bias_q     <= bias;
                prod_valid <= 1'b0;
            end
            if (state == FIN) begin
                phase <= sat_phase;
                ovf   <= sat_ovf;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac (Q4.12, N=16, LEN=4). Two instances
// share the stimulus: one sign-magnitude output, one two's complement.
module tb_neuron_mac;

    typedef logic [15:0] vec_t [4];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] bias = '0;
    logic [15:0] x = '0;
    logic [15:0] w = '0;

    logic        in_ready_a, out_valid_a, ovf_a, busy_a;
    logic [15:0] phase_a;
    logic        in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [15:0] phase_b;

    int checks = 0;
    int errors = 0;
    int hs = 0;

    always #5 clk = ~clk;

    neuron_mac #(.N(16), .Q(12), .LEN(4), .OUT_SM(1'b1)) u_sm (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_a), .x(x), .w(w),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .phase(phase_a), .ovf(ovf_a), .busy(busy_a)
    );

    neuron_mac #(.N(16), .Q(12), .LEN(4), .OUT_SM(1'b0)) u_tc (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_b), .x(x), .w(w),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .phase(phase_b), .ovf(ovf_b), .busy(busy_b)
    );

    // Output handshakes seen by the sign-magnitude instance
    always @(posedge clk) begin
        if (out_valid_a && out_ready) hs++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact dot product, bias scaled by 2^12, floor shift, clamp
    function automatic void model(input vec_t xs, input vec_t ws, input logic [15:0] b,
                                  output logic [15:0] sm, output logic [15:0] tc,
                                  output logic ov);
        longint s;
        longint r;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        end
        s += longint'($signed(b)) * 4096;
        r = s >>> 12;
        ov = 1'b0;
        if (r > 32767) begin
            r = 32767;
            ov = 1'b1;
        end else if (r < -32767) begin
            r = -32767;
            ov = 1'b1;
        end
        tc = r[15:0];
        sm = (r < 0) ? {1'b1, 15'(-r)} : r[15:0];
    endfunction

    task automatic run_job(input string tag, input vec_t xs, input vec_t ws, input logic [15:0] b,
                           input bit gaps, input int stall, input bit stray,
                           input logic [15:0] e_sm, input logic [15:0] e_tc, input logic e_ovf);
        int h0;
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = 16'($urandom);
        check({tag, "/busy"}, {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x = xs[i];
            w = ws[i];
            tick();
            in_valid = 1'b0;
            x = 16'($urandom);
            w = 16'($urandom);
            if (gaps && i < 3) tick();
        end
        check({tag, "/drain_ready"}, {31'd0, in_ready_a}, 32'd0);
        tick();
        check({tag, "/early_valid"}, {31'd0, out_valid_a}, 32'd0);
        tick();
        tick();
        check({tag, "/valid"}, {30'd0, out_valid_a, out_valid_b}, 32'd3);
        check({tag, "/phase_sm"}, {16'd0, phase_a}, {16'd0, e_sm});
        check({tag, "/phase_2c"}, {16'd0, phase_b}, {16'd0, e_tc});
        check({tag, "/ovf"}, {30'd0, ovf_a, ovf_b}, {30'd0, e_ovf, e_ovf});
        h0 = hs;
        for (int s = 0; s < stall; s++) begin
            if (stray && s == 1) start = 1'b1;
            tick();
            start = 1'b0;
            check({tag, "/stall_phase"}, {15'd0, out_valid_a, phase_a}, {15'd0, 1'b1, e_sm});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/drop_valid"}, {31'd0, out_valid_a}, 32'd0);
        check({tag, "/idle"}, {31'd0, busy_a}, 32'd0);
        check({tag, "/handshakes"}, 32'(hs - h0), 32'd1);
    endtask

    initial begin
        vec_t xs, ws;
        logic [15:0] b, e_sm, e_tc;
        logic        e_ov;

        // Reset state
        #2;
        check("reset_outs", {in_ready_a, out_valid_a, ovf_a, busy_a, 12'd0, phase_a},
              32'd0);
        tick();
        rst = 1'b1;
        tick();

        // 1: 1.0 * 0.5 x4 -> 2.0
        xs = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
        ws = '{16'h0800, 16'h0800, 16'h0800, 16'h0800};
        run_job("c1", xs, ws, 16'h0000, 1'b0, 0, 1'b0, 16'h2000, 16'h2000, 1'b0);

        // 2: 1.0 * -0.25 x4, bias -0.5 -> -1.5
        ws = '{16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
        run_job("c2", xs, ws, 16'hF800, 1'b0, 0, 1'b0, 16'h9800, 16'hE800, 1'b0);

        // 3: saturation both directions
        xs = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        ws = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        run_job("c3p", xs, ws, 16'h0000, 1'b0, 0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1);
        ws = '{16'h9000, 16'h9000, 16'h9000, 16'h9000};
        run_job("c3n", xs, ws, 16'h0000, 1'b0, 0, 1'b0, 16'hFFFF, 16'h8001, 1'b1);

        // 4: floor towards -inf, and a positive sub-lsb result to zero
        xs = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        ws = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
        run_job("c4n", xs, ws, 16'h0000, 1'b0, 0, 1'b0, 16'h8001, 16'hFFFF, 1'b0);
        xs = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
        run_job("c4p", xs, ws, 16'h0000, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);

        // 5: beat gaps, output stall of 5 cycles, stray start during OUT
        xs = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
        ws = '{16'h0800, 16'h0800, 16'h0800, 16'h0800};
        run_job("c5", xs, ws, 16'h0000, 1'b1, 5, 1'b1, 16'h2000, 16'h2000, 1'b0);

        // 6: asynchronous reset after two beats
        start = 1'b1;
        bias  = 16'h0000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x = 16'h1000;
            w = 16'h0800;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("c6/async_clear", {in_ready_a, out_valid_a, ovf_a, busy_a, 12'd0, phase_a},
              32'd0);
        repeat (3) tick();
        check("c6/no_valid", {30'd0, out_valid_a, busy_a}, 32'd0);
        #2;
        rst = 1'b1;
        tick();
        run_job("c6", xs, ws, 16'h0000, 1'b0, 0, 1'b0, 16'h2000, 16'h2000, 1'b0);

        // Randomised jobs against the reference model
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (j % 2 == 0) begin
                    xs[i] = 16'($urandom);
                    ws[i] = 16'($urandom);
                end else begin
                    xs[i] = 16'($signed(16'($urandom_range(0, 8191))) - 16'sd4096);
                    ws[i] = 16'($signed(16'($urandom_range(0, 8191))) - 16'sd4096);
                end
            end
            b = (j % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
            model(xs, ws, b, e_sm, e_tc, e_ov);
            run_job($sformatf("rnd%0d", j), xs, ws, b, 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), e_sm, e_tc, e_ov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
